// File: rtl/vrf_access_ctrl_if.sv
// Signal bundle between vrf_access_ctrl, the issue stage, the VRF and the lane execution unit.
// master = controller side, slave = environment (issue stage / VRF / execution unit) side.
interface vrf_access_ctrl_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned REG_NUM    = 32,
    parameter int unsigned LANES      = 4
);
    localparam int unsigned ADDR_B = $clog2(REG_NUM);
    localparam int unsigned ELEM_B = $clog2(LANES);

    logic                  instr_valid_i;
    logic                  instr_ready_o;
    logic [ADDR_B-1:0]     vs1_i;
    logic [ADDR_B-1:0]     vs2_i;
    logic [ADDR_B-1:0]     vs3_i;
    logic [ADDR_B-1:0]     vd_i;
    logic                  use_c_i;
    logic [ADDR_B-1:0]     a_addr_o;
    logic [ADDR_B-1:0]     b_addr_o;
    logic [ADDR_B-1:0]     c_addr_o;
    logic [ADDR_B-1:0]     wr_addr_o;
    logic                  is_c_used_o;
    logic                  rd_req_o;
    logic                  rd_op_ready_i;
    logic [ELEM_B-1:0]     rd_elem_cnt_o;
    logic [DATA_WIDTH-1:0] a_rdata_i;
    logic [DATA_WIDTH-1:0] b_rdata_i;
    logic [DATA_WIDTH-1:0] c_rdata_i;
    logic                  ex_valid_o;
    logic                  ex_ready_i;
    logic [DATA_WIDTH-1:0] ex_a_o;
    logic [DATA_WIDTH-1:0] ex_b_o;
    logic [DATA_WIDTH-1:0] ex_c_o;
    logic                  res_valid_i;
    logic                  res_ready_o;
    logic [DATA_WIDTH-1:0] res_data_i;
    logic                  wr_req_o;
    logic                  wr_en_o;
    logic [ELEM_B-1:0]     wr_elem_cnt_o;
    logic [DATA_WIDTH-1:0] wdata_o;
    logic                  wr_ready_o;

    modport master (
        input  instr_valid_i, vs1_i, vs2_i, vs3_i, vd_i, use_c_i, rd_op_ready_i,
               a_rdata_i, b_rdata_i, c_rdata_i, ex_ready_i, res_valid_i, res_data_i,
        output instr_ready_o, a_addr_o, b_addr_o, c_addr_o, wr_addr_o, is_c_used_o, rd_req_o,
               rd_elem_cnt_o, ex_valid_o, ex_a_o, ex_b_o, ex_c_o, res_ready_o, wr_req_o,
               wr_en_o, wr_elem_cnt_o, wdata_o, wr_ready_o
    );

    modport slave (
        output instr_valid_i, vs1_i, vs2_i, vs3_i, vd_i, use_c_i, rd_op_ready_i,
               a_rdata_i, b_rdata_i, c_rdata_i, ex_ready_i, res_valid_i, res_data_i,
        input  instr_ready_o, a_addr_o, b_addr_o, c_addr_o, wr_addr_o, is_c_used_o, rd_req_o,
               rd_elem_cnt_o, ex_valid_o, ex_a_o, ex_b_o, ex_c_o, res_ready_o, wr_req_o,
               wr_en_o, wr_elem_cnt_o, wdata_o, wr_ready_o
    );
endinterface

// File: rtl/vrf_access_ctrl.sv
// VRF operand/writeback initiator: reads one instruction's operands, streams element tuples to
// the lane execution unit and writes the returned results into vd. One instruction in flight.
module vrf_access_ctrl #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned REG_NUM    = 32,
    parameter int unsigned LANES      = 4
) (
    input  logic              clk_i,
    input  logic              resetn_i,
    vrf_access_ctrl_if.master bus
);
    localparam int unsigned ADDR_B = $clog2(REG_NUM);
    localparam int unsigned ELEM_B = $clog2(LANES);

    typedef logic [ELEM_B:0] cnt_t;
    localparam cnt_t LANES_CNT = cnt_t'(LANES);
    localparam cnt_t LAST_CNT  = cnt_t'(LANES - 1);

    typedef enum logic [1:0] {StIdle, StFetch, StWaitRd, StExec} state_e;

    state_e            r_state, w_state_nxt;
    logic [ADDR_B-1:0] r_a_addr, r_b_addr, r_c_addr, r_wr_addr;
    logic              r_use_c;
    cnt_t              r_rd_cnt, r_wr_cnt;
    logic              r_wr_armed;

    logic w_exec, w_accept, w_rd_fire, w_wr_last;

    assign w_exec    = (r_state == StExec);
    assign w_accept  = bus.instr_valid_i && bus.instr_ready_o;
    assign w_rd_fire = bus.ex_valid_o && bus.ex_ready_i;
    assign w_wr_last = bus.wr_ready_o;

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // rd_op_ready_i is high while the VRF sits idle, so it only counts once in WAIT_RD.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            StIdle:   if (bus.instr_valid_i) w_state_nxt = StFetch;
            StFetch:  w_state_nxt = StWaitRd;
            StWaitRd: if (bus.rd_op_ready_i) w_state_nxt = StExec;
            StExec:   if (w_wr_last) w_state_nxt = StIdle;
            default:  w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            r_a_addr   <= '0;
            r_b_addr   <= '0;
            r_c_addr   <= '0;
            r_wr_addr  <= '0;
            r_use_c    <= 1'b0;
            r_rd_cnt   <= '0;
            r_wr_cnt   <= '0;
            r_wr_armed <= 1'b0;
        end else begin
            if (w_accept) begin
                r_a_addr  <= bus.vs1_i;
                r_b_addr  <= bus.vs2_i;
                r_c_addr  <= bus.vs3_i;
                r_wr_addr <= bus.vd_i;
                r_use_c   <= bus.use_c_i;
            end
            if (w_wr_last) begin
                r_rd_cnt   <= '0;
                r_wr_cnt   <= '0;
                r_wr_armed <= 1'b0;
            end else begin
                if (w_rd_fire) r_rd_cnt <= r_rd_cnt + cnt_t'(1);
                if (bus.wr_en_o) r_wr_cnt <= r_wr_cnt + cnt_t'(1);
                if (bus.wr_req_o) r_wr_armed <= 1'b1;
            end
        end
    end

    assign bus.instr_ready_o = (r_state == StIdle);
    assign bus.rd_req_o      = (r_state == StFetch);
    assign bus.a_addr_o      = r_a_addr;
    assign bus.b_addr_o      = r_b_addr;
    assign bus.c_addr_o      = r_c_addr;
    assign bus.wr_addr_o     = r_wr_addr;
    assign bus.is_c_used_o   = r_use_c;

    assign bus.rd_elem_cnt_o = r_rd_cnt[ELEM_B-1:0];
    assign bus.ex_valid_o    = w_exec && (r_rd_cnt < LANES_CNT);
    assign bus.ex_a_o        = bus.a_rdata_i;
    assign bus.ex_b_o        = bus.b_rdata_i;
    assign bus.ex_c_o        = r_use_c ? bus.c_rdata_i : {DATA_WIDTH{1'b0}};

    // Results are held off during the wr_req_o cycle until the VRF write session is open.
    assign bus.wr_req_o      = w_exec && !r_wr_armed;
    assign bus.res_ready_o   = w_exec && r_wr_armed;
    assign bus.wr_en_o       = bus.res_valid_i && bus.res_ready_o;
    assign bus.wr_elem_cnt_o = r_wr_cnt[ELEM_B-1:0];
    assign bus.wdata_o       = bus.res_data_i;
    assign bus.wr_ready_o    = bus.wr_en_o && (r_wr_cnt == LAST_CNT);

    a_wr_behind_rd: assert property (@(posedge clk_i) disable iff (!resetn_i)
        r_wr_cnt <= r_rd_cnt);
endmodule

// File: tb/tb_vrf_access_ctrl.sv
// Directed bench for vrf_access_ctrl with a behavioural VRF (SRAM + read FSM) and a queue-based
// lane execution unit returning a+b+c.
module tb_vrf_access_ctrl;
    localparam int unsigned DW = 32;
    localparam int unsigned RN = 32;
    localparam int unsigned LN = 4;
    typedef logic [4:0] addr_t;

    logic clk_i = 1'b0;
    logic resetn_i;

    vrf_access_ctrl_if #(.DATA_WIDTH(DW), .REG_NUM(RN), .LANES(LN)) vif ();

    vrf_access_ctrl #(.DATA_WIDTH(DW), .REG_NUM(RN), .LANES(LN)) dut (
        .clk_i    (clk_i),
        .resetn_i (resetn_i),
        .bus      (vif)
    );

    always #5 clk_i = ~clk_i;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] mem [RN][LN];
    logic [31:0] res_q[$];
    int          age_q[$];
    int          wr_order[$];
    int busy = 0, res_lat = 0, cyc = 0;
    bit ex_toggle = 0, res_force = 0;
    logic        res_valid_m = 1'b0;
    logic [31:0] res_data_m = '0;
    int acc_cnt = 0, acc_cyc = 0, done_cnt = 0, done_cyc = 0, done_elem = 0, exv_cyc = 0;
    int rd_req_cnt = 0, wr_req_cnt = 0, wr_en_cnt = 0, tuple_changes = 0, stall_cnt = 0;

    assign vif.a_rdata_i   = mem[vif.a_addr_o][vif.rd_elem_cnt_o];
    assign vif.b_rdata_i   = mem[vif.b_addr_o][vif.rd_elem_cnt_o];
    assign vif.c_rdata_i   = mem[vif.c_addr_o][vif.rd_elem_cnt_o];
    assign vif.res_valid_i = res_force | res_valid_m;
    assign vif.res_data_i  = res_data_m;

    function automatic logic [7:0] ctl();
        return {vif.instr_ready_o, vif.rd_req_o, vif.ex_valid_o, vif.res_ready_o,
                vif.wr_en_o, vif.wr_req_o, vif.wr_ready_o, vif.is_c_used_o};
    endfunction

    function automatic logic [127:0] row(input int r);
        return {mem[r][3], mem[r][2], mem[r][1], mem[r][0]};
    endfunction

    // VRF + execution unit + monitor: sample just before each rising edge, update just after.
    initial begin : env
        logic s_rst, s_acc, s_rdreq, s_wrreq, s_wren, s_wrrdy, s_exv, s_exr, s_usec;
        logic prev_exv, stalled;
        logic [1:0] s_welem;
        logic [4:0] s_waddr;
        logic [31:0] s_wdata, s_sum;
        logic [97:0] s_tuple, stall_tuple;
        prev_exv = 1'b0;
        stalled = 1'b0;
        stall_tuple = '0;
        vif.ex_ready_i = 1'b1;
        vif.rd_op_ready_i = 1'b1;
        forever begin
            @(negedge clk_i);
            #4;
            s_rst   = resetn_i;
            s_acc   = vif.instr_valid_i && vif.instr_ready_o;
            s_rdreq = vif.rd_req_o;
            s_wrreq = vif.wr_req_o;
            s_wren  = vif.wr_en_o;
            s_wrrdy = vif.wr_ready_o;
            s_exv   = vif.ex_valid_o;
            s_exr   = vif.ex_ready_i;
            s_usec  = vif.is_c_used_o;
            s_welem = vif.wr_elem_cnt_o;
            s_waddr = vif.wr_addr_o;
            s_wdata = vif.wdata_o;
            s_sum   = vif.ex_a_o + vif.ex_b_o + vif.ex_c_o;
            s_tuple = {vif.rd_elem_cnt_o, vif.ex_a_o, vif.ex_b_o, vif.ex_c_o};
            @(posedge clk_i);
            #1;
            cyc++;
            if (!s_rst) begin
                res_q.delete();
                age_q.delete();
                busy = 0;
                stalled = 1'b0;
                prev_exv = 1'b0;
            end else begin
                if (s_acc) begin acc_cnt++; acc_cyc = cyc; end
                if (s_rdreq) rd_req_cnt++;
                if (s_wrreq) wr_req_cnt++;
                if (s_exv && !prev_exv) exv_cyc = cyc;
                prev_exv = s_exv;
                if (stalled && s_exv && s_tuple != stall_tuple) tuple_changes++;
                stalled = s_exv && !s_exr;
                if (stalled) begin stall_cnt++; stall_tuple = s_tuple; end
                if (s_wren) begin
                    mem[s_waddr][s_welem] = s_wdata;
                    wr_en_cnt++;
                    wr_order.push_back(int'(s_welem));
                    if (res_q.size() > 0) begin
                        void'(res_q.pop_front());
                        void'(age_q.pop_front());
                    end
                end
                if (s_wrrdy) begin done_cnt++; done_cyc = cyc; done_elem = int'(s_welem); end
                foreach (age_q[i]) age_q[i]++;
                if (s_exv && s_exr) begin res_q.push_back(s_sum); age_q.push_back(0); end
                if (s_rdreq) busy = s_usec ? 2 : 1;
                else if (busy > 0) busy--;
            end
            vif.rd_op_ready_i = (busy == 0);
            res_valid_m = (res_q.size() > 0) && (age_q[0] >= res_lat);
            res_data_m = (res_q.size() > 0) ? res_q[0] : 32'd0;
            vif.ex_ready_i = ex_toggle ? ~vif.ex_ready_i : 1'b1;
        end
    end

    task automatic issue(input int s1, input int s2, input int s3, input int d, input bit uc,
                         input string tag);
        int a0 = acc_cnt;
        bit ok = 1'b0;
        vif.vs1_i = addr_t'(s1);
        vif.vs2_i = addr_t'(s2);
        vif.vs3_i = addr_t'(s3);
        vif.vd_i = addr_t'(d);
        vif.use_c_i = uc;
        vif.instr_valid_i = 1'b1;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(negedge clk_i);
            ok = (acc_cnt != a0);
        end
        vif.instr_valid_i = 1'b0;
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL %s_accept: got no accept in 60 cycles, required accept", tag);
        end
    endtask

    task automatic wait_done(input int d0, input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk_i);
            ok = (done_cnt != d0);
        end
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL %s_done: got no wr_ready_o in 100 cycles, required one", tag);
        end
    endtask

    task automatic test_reset();
        resetn_i = 1'b0;
        vif.instr_valid_i = 1'b0;
        vif.vs1_i = '0; vif.vs2_i = '0; vif.vs3_i = '0; vif.vd_i = '0; vif.use_c_i = 1'b0;
        repeat (2) @(negedge clk_i);
        vectors++;
        if (ctl() !== 8'b1000_0000) begin
            miscompares++;
            $display("FAIL reset_ctl: got %b required 10000000", ctl());
        end
        vectors++;
        if ({vif.a_addr_o, vif.b_addr_o, vif.c_addr_o, vif.wr_addr_o, vif.rd_elem_cnt_o,
             vif.wr_elem_cnt_o} !== 24'd0) begin
            miscompares++;
            $display("FAIL reset_addr: got nonzero address/counter, required all 0");
        end
        resetn_i = 1'b1;
        repeat (2) @(negedge clk_i);
        vectors++;
        if (ctl() !== 8'b1000_0000) begin
            miscompares++;
            $display("FAIL idle_ctl: got %b required 10000000", ctl());
        end
    endtask

    task automatic test_basic();
        int d0 = done_cnt, r0 = rd_req_cnt, w0 = wr_req_cnt;
        issue(1, 2, 0, 3, 1'b0, "basic");
        wait_done(d0, "basic");
        vectors++;
        if (rd_req_cnt - r0 != 1) begin
            miscompares++;
            $display("FAIL basic_rd_req: got %0d pulses required 1", rd_req_cnt - r0);
        end
        vectors++;
        if (wr_req_cnt - w0 != 1) begin
            miscompares++;
            $display("FAIL basic_wr_req: got %0d pulses required 1", wr_req_cnt - w0);
        end
        vectors++;
        if (done_elem != 3) begin
            miscompares++;
            $display("FAIL basic_last_elem: got %0d required 3", done_elem);
        end
        vectors++;
        if (exv_cyc - acc_cyc != 4) begin
            miscompares++;
            $display("FAIL basic_ex_latency: got %0d required 4", exv_cyc - acc_cyc);
        end
        vectors++;
        if (done_cyc - acc_cyc != 8) begin
            miscompares++;
            $display("FAIL basic_wr_latency: got %0d required 8", done_cyc - acc_cyc);
        end
        vectors++;
        if (row(3) !== {32'd44, 32'd33, 32'd22, 32'd11}) begin
            miscompares++;
            $display("FAIL basic_v3: got %h required 44,33,22,11", row(3));
        end
        vectors++;
        if (ctl() !== 8'b1000_0000) begin
            miscompares++;
            $display("FAIL basic_idle: got %b required 10000000", ctl());
        end
    endtask

    task automatic test_use_c();
        int d0 = done_cnt;
        issue(1, 2, 4, 3, 1'b1, "use_c");
        wait_done(d0, "use_c");
        vectors++;
        if (exv_cyc - acc_cyc != 5) begin
            miscompares++;
            $display("FAIL usec_ex_latency: got %0d required 5", exv_cyc - acc_cyc);
        end
        vectors++;
        if (done_cyc - acc_cyc != 9) begin
            miscompares++;
            $display("FAIL usec_wr_latency: got %0d required 9", done_cyc - acc_cyc);
        end
        vectors++;
        if (row(3) !== {32'd49, 32'd38, 32'd27, 32'd16}) begin
            miscompares++;
            $display("FAIL usec_v3: got %h required 49,38,27,16", row(3));
        end
        vectors++;
        if ({ctl(), vif.c_addr_o} !== {8'b1000_0001, 5'd4}) begin
            miscompares++;
            $display("FAIL usec_latched: got %b/%0d required 10000001/4", ctl(), vif.c_addr_o);
        end
    endtask

    task automatic test_backpressure();
        int d0 = done_cnt, e0 = wr_en_cnt, o0 = wr_order.size();
        int t0 = tuple_changes, s0 = stall_cnt;
        logic [7:0] order;
        ex_toggle = 1'b1;
        res_lat = 3;
        issue(1, 2, 0, 6, 1'b0, "bp");
        wait_done(d0, "bp");
        ex_toggle = 1'b0;
        res_lat = 0;
        vectors++;
        if (wr_en_cnt - e0 != 4) begin
            miscompares++;
            $display("FAIL bp_wr_en_count: got %0d required 4", wr_en_cnt - e0);
        end
        order = 8'hff;
        if (wr_order.size() >= o0 + 4)
            order = {2'(wr_order[o0 + 3]), 2'(wr_order[o0 + 2]), 2'(wr_order[o0 + 1]),
                     2'(wr_order[o0])};
        vectors++;
        if (order !== 8'b11_10_01_00) begin
            miscompares++;
            $display("FAIL bp_wr_order: got %b required 11100100", order);
        end
        vectors++;
        if (stall_cnt == s0) begin
            miscompares++;
            $display("FAIL bp_stalls: got 0 stalled cycles required >0");
        end
        vectors++;
        if (tuple_changes != t0) begin
            miscompares++;
            $display("FAIL bp_tuple_stable: got %0d changes required 0", tuple_changes - t0);
        end
        vectors++;
        if (row(6) !== {32'd44, 32'd33, 32'd22, 32'd11}) begin
            miscompares++;
            $display("FAIL bp_v6: got %h required 44,33,22,11", row(6));
        end
    endtask

    task automatic test_early_result();
        int d0 = done_cnt;
        bit ok = 1'b0;
        issue(3, 1, 0, 7, 1'b0, "early");
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk_i);
            ok = vif.wr_req_o;
        end
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL early_wr_req: got none in 20 cycles required 1");
        end
        res_force = 1'b1;
        #1;
        vectors++;
        if ({vif.res_valid_i, vif.res_ready_o, vif.wr_en_o} !== 3'b100) begin
            miscompares++;
            $display("FAIL early_backpressure: got %b required 100",
                     {vif.res_valid_i, vif.res_ready_o, vif.wr_en_o});
        end
        @(negedge clk_i);
        res_force = 1'b0;
        #1;
        vectors++;
        if ({vif.wr_en_o, vif.wr_elem_cnt_o} !== 3'b1_00) begin
            miscompares++;
            $display("FAIL early_elem0: got %b required 100", {vif.wr_en_o, vif.wr_elem_cnt_o});
        end
        wait_done(d0, "early");
        vectors++;
        if (row(7) !== {32'd53, 32'd41, 32'd29, 32'd17}) begin
            miscompares++;
            $display("FAIL early_v7: got %h required 53,41,29,17", row(7));
        end
    endtask

    task automatic test_reset_mid();
        int e0 = wr_en_cnt, d0;
        bit ok = 1'b0;
        issue(1, 2, 0, 5, 1'b0, "rstmid");
        for (int i = 0; i < 30 && !ok; i++) begin
            @(negedge clk_i);
            ok = (wr_en_cnt - e0 >= 2);
        end
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL rstmid_two_writes: got %0d writes required 2", wr_en_cnt - e0);
        end
        #2;
        resetn_i = 1'b0;
        #1;
        vectors++;
        if (ctl() !== 8'b1000_0000) begin
            miscompares++;
            $display("FAIL rstmid_ctl: got %b required 10000000", ctl());
        end
        vectors++;
        if ({vif.a_addr_o, vif.b_addr_o, vif.wr_addr_o, vif.rd_elem_cnt_o,
             vif.wr_elem_cnt_o} !== 19'd0) begin
            miscompares++;
            $display("FAIL rstmid_addr: got nonzero address/counter, required all 0");
        end
        repeat (2) @(negedge clk_i);
        resetn_i = 1'b1;
        @(negedge clk_i);
        vectors++;
        if (row(5) !== {32'd103, 32'd102, 32'd22, 32'd11}) begin
            miscompares++;
            $display("FAIL rstmid_v5: got %h required 103,102,22,11", row(5));
        end
        d0 = done_cnt;
        issue(2, 1, 0, 8, 1'b0, "rstmid2");
        wait_done(d0, "rstmid2");
        vectors++;
        if (row(8) !== {32'd44, 32'd33, 32'd22, 32'd11}) begin
            miscompares++;
            $display("FAIL rstmid_v8: got %h required 44,33,22,11", row(8));
        end
    endtask

    task automatic test_back_to_back();
        int a0 = acc_cnt, d0 = done_cnt, first_acc;
        bit ok = 1'b0;
        vif.vs1_i = 5'd1; vif.vs2_i = 5'd2; vif.vs3_i = 5'd0; vif.vd_i = 5'd9;
        vif.use_c_i = 1'b0;
        vif.instr_valid_i = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk_i);
            ok = (acc_cnt != a0);
        end
        first_acc = acc_cyc;
        vif.vs1_i = 5'd9; vif.vd_i = 5'd10;
        #1;
        vectors++;
        if ({vif.a_addr_o, vif.wr_addr_o} !== {5'd1, 5'd9}) begin
            miscompares++;
            $display("FAIL b2b_latched: got %0d/%0d required 1/9", vif.a_addr_o, vif.wr_addr_o);
        end
        ok = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(negedge clk_i);
            ok = (acc_cnt - a0 == 2);
        end
        vif.instr_valid_i = 1'b0;
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL b2b_accept: got %0d accepts required 2", acc_cnt - a0);
        end
        vectors++;
        if (done_cnt - d0 != 1) begin
            miscompares++;
            $display("FAIL b2b_first_done: got %0d completions required 1", done_cnt - d0);
        end
        vectors++;
        if (acc_cyc - first_acc != 9) begin
            miscompares++;
            $display("FAIL b2b_accept_gap: got %0d required 9", acc_cyc - first_acc);
        end
        wait_done(d0 + 1, "b2b");
        vectors++;
        if (row(9) !== {32'd44, 32'd33, 32'd22, 32'd11}) begin
            miscompares++;
            $display("FAIL b2b_v9: got %h required 44,33,22,11", row(9));
        end
        vectors++;
        if (row(10) !== {32'd84, 32'd63, 32'd42, 32'd21}) begin
            miscompares++;
            $display("FAIL b2b_v10: got %h required 84,63,42,21", row(10));
        end
    endtask

    initial begin
        for (int r = 0; r < int'(RN); r++)
            for (int e = 0; e < int'(LN); e++) mem[r][e] = 32'd0;
        for (int e = 0; e < int'(LN); e++) begin
            mem[1][e] = 32'(e + 1);
            mem[2][e] = 32'(10 * (e + 1));
            mem[4][e] = 32'd5;
            mem[5][e] = 32'(100 + e);
        end
        test_reset();
        test_basic();
        test_use_c();
        test_backpressure();
        test_early_result();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion by 200000 time units, required finish");
        $fatal(1, "watchdog expired");
    end
endmodule
